// File: rtl/cpu_bus_master_pkg.sv
// Shared types and constants for the pixel-processor CPU register bus.
// Used by the bus initiator and the pp CPU slave.
package cpu_bus_master_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 32;

    localparam logic [CPU_DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_STROBE = 5'b00100,
        ST_HOLD   = 5'b01000,
        ST_TURN   = 5'b10000
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cpu_bus_master_if.sv
// Command/response handshake between a requester and the bus initiator.
// master = requester side, slave = the cpu_bus_master itself.
interface cpu_bus_master_if;
    import cpu_bus_master_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [CPU_ADDR_W-1:0] cmd_addr;
    logic [CPU_DATA_W-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [CPU_DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/cpu_bus_master.sv
// Initiator for the CPU register bus: one command in, one bus cycle out,
// one response strobe back. Every output is taken straight from a flop.
module cpu_bus_master
    import cpu_bus_master_pkg::*;
#(
    parameter int unsigned           TIMEOUT_CYC = 255,
    parameter logic [CPU_DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                  clk_100m,
    input  logic                  rst_n,
    cpu_bus_master_if.slave       host,
    output logic                  CPU_CS_N,
    output logic                  CPU_RD_N,
    output logic                  CPU_WE_N,
    output logic [CPU_ADDR_W-1:0] CPU_ADDR,
    inout  wire  [CPU_DATA_W-1:0] CPU_DATA,
    input  logic                  CPU_RDY_N
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_t                state;
    logic [TW-1:0]         timer;
    cmd_t                  cmd_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [CPU_DATA_W-1:0] rsp_rdata_q;
    logic                  cs_n_q;
    logic                  rd_n_q;
    logic                  we_n_q;
    logic                  data_oe;
    logic                  timer_last;

    assign timer_last = (timer == T_LAST);

    assign host.cmd_ready = ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.rsp_rdata = rsp_rdata_q;

    assign CPU_CS_N = cs_n_q;
    assign CPU_RD_N = rd_n_q;
    assign CPU_WE_N = we_n_q;
    assign CPU_ADDR = cmd_q.addr;
    assign CPU_DATA = data_oe ? cmd_q.wdata : 'z;

    // Bus cycle sequencer: each branch loads the outputs of the next state.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cmd_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (host.cmd_valid) begin
                        cmd_q.wr    <= host.cmd_wr;
                        cmd_q.addr  <= host.cmd_addr;
                        cmd_q.wdata <= host.cmd_wdata;
                        ready_q     <= 1'b0;
                        cs_n_q      <= 1'b0;
                        data_oe     <= host.cmd_wr;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    timer  <= '0;
                    rd_n_q <= cmd_q.wr;
                    we_n_q <= !cmd_q.wr;
                    state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    // A ready arriving on the timeout cycle still wins.
                    if (!CPU_RDY_N) begin
                        rsp_rdata_q <= cmd_q.wr ? '0 : CPU_DATA;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rd_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (timer_last) begin
                        rsp_rdata_q <= cmd_q.wr ? '0 : ERR_RDATA;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rd_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_HOLD: begin
                    timer   <= '0;
                    cs_n_q  <= 1'b1;
                    data_oe <= 1'b0;
                    state   <= ST_TURN;
                end
                ST_TURN: begin
                    // A ready stuck low only stretches turnaround.
                    if (CPU_RDY_N || timer_last) begin
                        timer   <= '0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer   <= '0;
                    ready_q <= 1'b1;
                    cs_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    data_oe <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
